lane_hit_judge: RTL and testbench
=================================

# lane_hit_judge

Per-lane hit judge for one falling note lane. Consumes the note's vertical position from the lane's sprite mover, plus the lane's fret key from the keyboard decoder. Grades each key press against a fixed strike zone and reports one judgement per note: perfect, good or miss. Maintains the lane's score and consecutive-hit streak for the HUD/score-display stage downstream.

## Interface
Parameters:
- HIT_Y_TOP, 10'd400, first note_y_pos row of the strike zone (inclusive)
- HIT_Y_BOT, 10'd460, last note_y_pos row of the strike zone (inclusive)
- PERF_Y_TOP, 10'd420, first row of the perfect sub-zone (inclusive)
- PERF_Y_BOT, 10'd440, last row of the perfect sub-zone (inclusive)
- GOOD_PTS, 16'd50, points for a good hit
- PERF_PTS, 16'd100, points for a perfect hit
- STREAK_X2, 8'd10, streak value at or above which points are doubled

Ports:
- Clk, input, 1, 50 MHz system clock; the only clock
- Reset, input, 1, synchronous, active-high
- note_y_pos, input, 10, top row of the lane note; 0 means parked or recycled
- key, input, 1, fret key level, active-high, synchronous to Clk
- hit_perfect, output, 1, one-cycle pulse on a perfect judgement
- hit_good, output, 1, one-cycle pulse on a good judgement
- miss, output, 1, one-cycle pulse when a note leaves the zone unjudged
- ghost, output, 1, one-cycle pulse on a key press with no note in the zone
- score, output, 16, accumulated lane score, saturating
- streak, output, 8, consecutive good-or-perfect count, saturating

## Operation
- Key edge: key_q is a register holding key; key_rise = key & ~key_q.
- Zone decode, combinational:
  - in_zone = HIT_Y_TOP <= note_y_pos <= HIT_Y_BOT
  - in_perf = PERF_Y_TOP <= note_y_pos <= PERF_Y_BOT
  - past_zone = note_y_pos > HIT_Y_BOT
- FSM states are ARMED and DONE. Reset state is ARMED.
- ARMED, key_rise & in_zone:
  - Pulse hit_perfect if in_perf, otherwise pulse hit_good.
  - Add pts to score, where pts = PERF_PTS or GOOD_PTS, doubled (<<1) when the pre-increment streak >= STREAK_X2.
  - Increment streak, then go to DONE.
- ARMED, past_zone: pulse miss, clear streak to 0, go to DONE.
- ARMED, key_rise & ~in_zone & ~past_zone: pulse ghost, clear streak to 0, stay in ARMED.
- DONE, note_y_pos == 0: go to ARMED. The note has recycled.
- DONE, key_rise: pulse ghost, clear streak. State is unchanged.
- Arithmetic:
  - score is a 17-bit internal sum that clamps to 16'hFFFF.
  - streak holds at 8'hFF.
- Simultaneous events:
  - key_rise and past_zone in the same ARMED cycle: miss only. The key press is consumed, with no ghost pulse.
  - At most one pulse output is high in any cycle.
- Reset mid-operation, including mid-note: state returns to ARMED, and all outputs and key_q clear on the same edge.

## Timing
- Every output is registered.
- Reset values: all four pulse outputs 0, score 0, streak 0, key_q 0.
- Latency: if key first samples 1 at edge N (with key_q = 0), then the judgement pulse, score and streak are all visible after edge N. The pulse is high for exactly the one cycle up to edge N+1.
- Zone membership uses note_y_pos as sampled at the judging edge.
- Held key: produces no further judgements until key is released and pressed again.
- A note that enters the zone while key is already held is not hit. It misses unless the key is re-pressed.
- The note moves at most one step (3 rows) per frame, so the judge evaluates every Clk cycle. There is no frame_clk dependency.

## Structure
- Shared package guitar_pkg holds:
  - judge_state_t (enum logic {ARMED, DONE})
  - the point and zone default constants, so that all lane instances share them
- One natural sub-module, rise_detect: a key_q register plus the key_rise output. It is reused by the other lane judges and by the start/pause control.
- Score saturation sits inline in this block.

## Test plan
- Reset, then hold note_y_pos = 430 and press key for 3 cycles -> one hit_perfect pulse on the first edge, score 100, streak 1, state DONE. No second pulse while the key is held.
- note_y_pos = 405, key rise -> hit_good, score +50. Then set note_y_pos = 0 -> state ARMED.
- Sweep note_y_pos 0→480 in steps of 3 with no key -> exactly one miss, at the first value > 460, and streak clears to 0.
- Key rise at note_y_pos = 200 -> ghost pulse, streak 5→0, score unchanged, state stays ARMED.
- Streak = 10, key rise at note_y_pos = 430 -> score +200, streak 11.
- Score preset near 16'hFFC0, perfect hit with multiplier -> score 16'hFFFF.
- Assert Reset mid-zone with state DONE -> all outputs 0 and state ARMED the next cycle.

Source files
------------

// File: rtl/guitar_pkg.sv
// Shared types and default constants for the guitar lane judges.
// Every lane instance draws its zone and point defaults from here.
package guitar_pkg;

    typedef enum logic {
        ARMED = 1'b0,
        DONE  = 1'b1
    } judge_state_t;

    localparam logic [9:0]  HIT_Y_TOP_DEF  = 10'd400;
    localparam logic [9:0]  HIT_Y_BOT_DEF  = 10'd460;
    localparam logic [9:0]  PERF_Y_TOP_DEF = 10'd420;
    localparam logic [9:0]  PERF_Y_BOT_DEF = 10'd440;
    localparam logic [15:0] GOOD_PTS_DEF   = 16'd50;
    localparam logic [15:0] PERF_PTS_DEF   = 16'd100;
    localparam logic [7:0]  STREAK_X2_DEF  = 8'd10;

    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        sat_inc8 = (a == 8'hFF) ? 8'hFF : a + 8'd1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Key edge detector: registers the key level and flags a press.
// Shared by the lane judges and the start/pause control.
module rise_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic key,
    output logic key_rise
);

    logic key_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            key_q <= 1'b0;
        else
            key_q <= key;
    end

    assign key_rise = key & ~key_q;

endmodule

// File: rtl/lane_hit_judge.sv
// Per-lane hit judge: grades fret presses against the strike zone,
// and keeps the lane score and hit streak.
module lane_hit_judge
    import guitar_pkg::*;
#(
    parameter logic [9:0]  HIT_Y_TOP  = HIT_Y_TOP_DEF,
    parameter logic [9:0]  HIT_Y_BOT  = HIT_Y_BOT_DEF,
    parameter logic [9:0]  PERF_Y_TOP = PERF_Y_TOP_DEF,
    parameter logic [9:0]  PERF_Y_BOT = PERF_Y_BOT_DEF,
    parameter logic [15:0] GOOD_PTS   = GOOD_PTS_DEF,
    parameter logic [15:0] PERF_PTS   = PERF_PTS_DEF,
    parameter logic [7:0]  STREAK_X2  = STREAK_X2_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  note_y_pos,
    input  logic        key,
    output logic        hit_perfect,
    output logic        hit_good,
    output logic        miss,
    output logic        ghost,
    output logic [15:0] score,
    output logic [7:0]  streak
);

    judge_state_t state, state_nxt;

    logic        key_rise;
    logic        in_zone;
    logic        in_perf;
    logic        past_zone;
    logic [15:0] base_pts;
    logic [15:0] pts;

    logic        hp_nxt;
    logic        hg_nxt;
    logic        miss_nxt;
    logic        ghost_nxt;
    logic [15:0] score_nxt;
    logic [7:0]  streak_nxt;

    rise_detect u_rise (
        .Clk      (Clk),
        .Reset    (Reset),
        .key      (key),
        .key_rise (key_rise)
    );

    assign in_zone   = (note_y_pos >= HIT_Y_TOP) && (note_y_pos <= HIT_Y_BOT);
    assign in_perf   = (note_y_pos >= PERF_Y_TOP) && (note_y_pos <= PERF_Y_BOT);
    assign past_zone = note_y_pos > HIT_Y_BOT;

    // Multiplier looks at the streak before this hit is counted.
    assign base_pts = in_perf ? PERF_PTS : GOOD_PTS;
    assign pts      = (streak >= STREAK_X2) ? (base_pts << 1) : base_pts;

    always_comb begin
        state_nxt  = state;
        hp_nxt     = 1'b0;
        hg_nxt     = 1'b0;
        miss_nxt   = 1'b0;
        ghost_nxt  = 1'b0;
        score_nxt  = score;
        streak_nxt = streak;
        unique case (state)
            ARMED: begin
                if (past_zone) begin
                    // A press on the same cycle is swallowed by the miss.
                    miss_nxt   = 1'b1;
                    streak_nxt = 8'd0;
                    state_nxt  = DONE;
                end else if (key_rise && in_zone) begin
                    hp_nxt     = in_perf;
                    hg_nxt     = ~in_perf;
                    score_nxt  = sat_add16(score, pts);
                    streak_nxt = sat_inc8(streak);
                    state_nxt  = DONE;
                end else if (key_rise) begin
                    ghost_nxt  = 1'b1;
                    streak_nxt = 8'd0;
                end
            end
            DONE: begin
                if (key_rise) begin
                    ghost_nxt  = 1'b1;
                    streak_nxt = 8'd0;
                end
                if (note_y_pos == 10'd0)
                    state_nxt = ARMED;
            end
            default: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ARMED;
            hit_perfect <= 1'b0;
            hit_good    <= 1'b0;
            miss        <= 1'b0;
            ghost       <= 1'b0;
            score       <= 16'd0;
            streak      <= 8'd0;
        end else begin
            state       <= state_nxt;
            hit_perfect <= hp_nxt;
            hit_good    <= hg_nxt;
            miss        <= miss_nxt;
            ghost       <= ghost_nxt;
            score       <= score_nxt;
            streak      <= streak_nxt;
        end
    end

endmodule

// File: tb/tb_lane_hit_judge.sv
// Scoreboard bench for lane_hit_judge: directed plan plus random play,
// checked against a behavioural lane model.
module tb_lane_hit_judge;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  note_y_pos = 10'd0;
    logic        key = 1'b0;
    logic        hit_perfect;
    logic        hit_good;
    logic        miss;
    logic        ghost;
    logic [15:0] score;
    logic [7:0]  streak;

    always #10 Clk = ~Clk;

    lane_hit_judge dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .note_y_pos  (note_y_pos),
        .key         (key),
        .hit_perfect (hit_perfect),
        .hit_good    (hit_good),
        .miss        (miss),
        .ghost       (ghost),
        .score       (score),
        .streak      (streak)
    );

    typedef struct {
        bit       hp;
        bit       hg;
        bit       ms;
        bit       gh;
        int       sc;
        int       st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   done_stim = 0;

    // Behavioural lane model
    bit m_armed = 1;
    bit m_kq = 0;
    int m_score = 0;
    int m_streak = 0;

    task automatic model(input int y, input bit k, input bit r);
        exp_t e;
        bit   rise;
        int   p;
        e.hp = 0; e.hg = 0; e.ms = 0; e.gh = 0;
        if (r) begin
            m_armed = 1; m_kq = 0; m_score = 0; m_streak = 0;
        end else begin
            rise = k && !m_kq;
            m_kq = k;
            if (m_armed) begin
                if (y > 460) begin
                    e.ms = 1; m_streak = 0; m_armed = 0;
                end else if (rise && y >= 400) begin
                    if (y >= 420 && y <= 440) begin
                        e.hp = 1; p = 100;
                    end else begin
                        e.hg = 1; p = 50;
                    end
                    if (m_streak >= 10) p = p * 2;
                    m_score = m_score + p;
                    if (m_score > 65535) m_score = 65535;
                    if (m_streak < 255) m_streak = m_streak + 1;
                    m_armed = 0;
                end else if (rise) begin
                    e.gh = 1; m_streak = 0;
                end
            end else begin
                if (rise) begin
                    e.gh = 1; m_streak = 0;
                end
                if (y == 0) m_armed = 1;
            end
        end
        e.sc = m_score;
        e.st = m_streak;
        q.push_back(e);
    endtask

    task automatic step(input int y, input bit k, input bit r = 0);
        @(negedge Clk);
        note_y_pos = y[9:0];
        key = k;
        Reset = r;
        model(y, k, r);
    endtask

    task automatic note_hit(input int y);
        step(y, 1);
        step(y, 0);
        step(0, 0);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("hit_perfect", int'(hit_perfect), int'(e.hp));
                chk("hit_good", int'(hit_good), int'(e.hg));
                chk("miss", int'(miss), int'(e.ms));
                chk("ghost", int'(ghost), int'(e.gh));
                chk("score", int'(score), e.sc);
                chk("streak", int'(streak), e.st);
                chk("one_hot", int'($countones({hit_perfect, hit_good, miss, ghost}) <= 1), 1);
            end
        end
    end

    initial begin : driver
        int y;
        bit k;
        step(0, 0, 1);
        step(0, 0, 1);
        // perfect hit with key held for 3 cycles
        step(430, 1); step(430, 1); step(430, 1); step(430, 0);
        step(0, 0);
        // good hit, then recycle
        step(405, 1); step(405, 0); step(0, 0);
        // sweep with no key: one miss past 460
        for (int v = 0; v <= 480; v += 3) step(v, 0);
        step(0, 0);
        // build streak 5, then ghost at 200
        for (int i = 0; i < 5; i++) note_hit(430);
        step(200, 1); step(200, 0);
        step(0, 0);
        // streak 10 -> doubled perfect
        for (int i = 0; i < 10; i++) note_hit(430);
        note_hit(430);
        // press in DONE -> ghost
        step(430, 1); step(430, 0); step(430, 1); step(430, 0);
        step(0, 0);
        // key held before the note enters: miss
        for (int v = 300; v <= 480; v += 3) step(v, 1);
        step(0, 0);
        // zone edges
        note_hit(400); note_hit(460); note_hit(419); note_hit(420);
        note_hit(440); note_hit(441); note_hit(399);
        step(0, 0);
        // reset mid-zone in DONE
        step(430, 1); step(430, 1, 1); step(430, 1); step(430, 0);
        step(0, 0); step(430, 1); step(430, 0); step(0, 0);
        // random play
        y = 0; k = 0;
        for (int c = 0; c < 3000; c++) begin
            if (y == 0) begin
                if ($urandom_range(0, 7) == 0) y = 3 * $urandom_range(1, 130);
            end else if ($urandom_range(0, 1) == 0) begin
                y = y + 3;
                if (y > 500) y = 0;
            end
            if ($urandom_range(0, 5) == 0) k = !k;
            step(y, k, $urandom_range(0, 399) == 0);
        end
        // saturation: long perfect run from reset
        step(0, 0, 1);
        for (int i = 0; i < 340; i++) note_hit(430);
        step(430, 1); step(430, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: queue %0d expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
